// File: rtl/maj_chain_pipe.sv
// maj_chain_pipe: a chain of STAGES bitwise majority stages, one register rank
// per stage. Each rank carries a valid bit. The whole chain advances together
// whenever the output is empty or being consumed, so bubbles stay in place.
// Per-stage 3-bit inversion masks can be written only while the chain is idle.

// One majority stage: optionally inverts each operand, then takes the bitwise
// majority. The operands are ordered (side x, side y, carry); for stage 0 they
// are (a, b, c).
module maj_stage #(
    parameter int W = 1
) (
    input  logic [W-1:0] p,
    input  logic [W-1:0] q,
    input  logic [W-1:0] s,
    input  logic [2:0]   inv,
    output logic [W-1:0] r
);
    logic [W-1:0] pi;
    logic [W-1:0] qi;
    logic [W-1:0] si;

    // Apply the replicated mask bits, then compute the bitwise majority.
    always_comb begin
        pi = p ^ {W{inv[0]}};
        qi = q ^ {W{inv[1]}};
        si = s ^ {W{inv[2]}};
        r  = (pi & qi) | (pi & si) | (qi & si);
    end
endmodule

module maj_chain_pipe #(
    parameter  int STAGES = 6,
    parameter  int W      = 1,
    localparam int SW     = (STAGES > 2) ? $clog2(STAGES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_a,
    input  logic [W-1:0]            in_b,
    input  logic [W-1:0]            in_c,
    input  logic [(STAGES-1)*W-1:0] in_x,
    input  logic [(STAGES-1)*W-1:0] in_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_w,
    input  logic                    cfg_we,
    input  logic [SW-1:0]           cfg_stage,
    input  logic [2:0]              cfg_inv,
    output logic                    cfg_err,
    output logic                    busy,
    output logic [15:0]             out_count
);
    // The limit is one bit wider than the index so that power-of-two STAGES
    // still gives a meaningful compare.
    localparam logic [SW:0] STG_LIM = (SW+1)'(STAGES);

    logic                         adv;
    logic                         cfg_ok;
    logic [STAGES-1:0]            vld;
    logic [STAGES-1:0][W-1:0]     data;
    logic [STAGES-1:0][W-1:0]     nxt;
    logic [STAGES-1:0][2:0]       mask;
    logic [15:0]                  cnt;
    logic                         err_q;

    // The chain moves only as a whole. A stalled output freezes every rank.
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[STAGES-1];
    assign out_w     = data[STAGES-1];
    assign busy      = |vld;
    assign cfg_err   = err_q;
    assign out_count = cnt;

    // A mask write is legal only when nothing is in flight or arriving, so a
    // token never sees masks change partway down the chain.
    assign cfg_ok = cfg_we & ~busy & ~in_valid & ({1'b0, cfg_stage} < STG_LIM);

    // Stage 0 takes its operands directly from the input port.
    maj_stage #(.W(W)) u_stage0 (
        .p   (in_a),
        .q   (in_b),
        .s   (in_c),
        .inv (mask[0]),
        .r   (nxt[0])
    );

    // Stages 1..STAGES-1. Each stage owns a k-deep delay line for its side
    // operands. The line is loaded at acceptance and shifts with the chain, so
    // the slice arrives in step with the token that brought it.
    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        logic [k-1:0][W-1:0] xd;
        logic [k-1:0][W-1:0] yd;

        // Shift the side operands alongside the valid/data ranks.
        always_ff @(posedge clk) begin
            if (adv) begin
                xd[0] <= in_x[(k-1)*W +: W];
                yd[0] <= in_y[(k-1)*W +: W];
                for (int i = 1; i < k; i++) begin
                    xd[i] <= xd[i-1];
                    yd[i] <= yd[i-1];
                end
            end
        end

        maj_stage #(.W(W)) u_stage (
            .p   (xd[k-1]),
            .q   (yd[k-1]),
            .s   (data[k-1]),
            .inv (mask[k]),
            .r   (nxt[k])
        );
    end

    // Valid shift register. Bubbles shift along with tokens, and reset drops
    // everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n)
            vld <= '0;
        else if (adv)
            vld <= {vld[STAGES-2:0], in_valid};
    end

    // Data ranks load the masked majority results. Their reset value is
    // irrelevant because the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (adv)
            data <= nxt;
    end

    // Mask registers. Reset returns the block to a plain majority chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask <= '0;
        end else if (cfg_ok) begin
            for (int k = 0; k < STAGES; k++)
                if (cfg_stage == SW'(k))
                    mask[k] <= cfg_inv;
        end
    end

    // A rejected write pulses cfg_err in the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= cfg_we & ~cfg_ok;
    end

    // Count completed output handshakes. The counter wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (out_valid & out_ready)
            cnt <= cnt + 16'd1;
    end
endmodule

// File: tb/tb_maj_chain_pipe.sv
// Directed bench for maj_chain_pipe (STAGES=6, W=1): table-driven streams plus
// hand-written sequences for latency, stall, mask config and mid-stream reset.
module tb_maj_chain_pipe;
    localparam int STAGES = 6;
    localparam int W      = 1;
    localparam int SW     = 3;

    typedef struct {
        logic       a, b, c;
        logic [4:0] x, y;
        logic       exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_a = '0, in_b = '0, in_c = '0;
    logic [4:0]      in_x = '0, in_y = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [W-1:0]    out_w;
    logic            cfg_we = 1'b0;
    logic [SW-1:0]   cfg_stage = '0;
    logic [2:0]      cfg_inv = '0;
    logic            cfg_err;
    logic            busy;
    logic [15:0]     out_count;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    vec_t tab [10];
    logic got_w [$];
    int   got_cyc [$];

    maj_chain_pipe #(.STAGES(STAGES), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w),
        .cfg_we(cfg_we), .cfg_stage(cfg_stage), .cfg_inv(cfg_inv),
        .cfg_err(cfg_err), .busy(busy), .out_count(out_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output handshake (value and cycle) for ordering and gap checks.
    always @(negedge clk)
        if (rst_n && out_valid && out_ready) begin
            got_w.push_back(out_w[0]);
            got_cyc.push_back(cyc);
        end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic apply(input int i);
        in_a = tab[i].a; in_b = tab[i].b; in_c = tab[i].c;
        in_x = tab[i].x; in_y = tab[i].y;
    endtask

    task automatic wait_out(input string name, input logic exp);
        bit found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (out_valid) found = 1;
        end
        if (!found) chk({name, "_timeout"}, 0, 1);
        else chk(name, out_w, exp);
    endtask

    // Send one table vector into an idle chain and check its result (and optionally its latency).
    task automatic single(input string name, input int i, input logic exp, input bit lat);
        bit found = 0;
        int n = 0;
        @(posedge clk); #1;
        apply(i); in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        for (int k = 1; k <= 30 && !found; k++) begin
            @(negedge clk);
            if (out_valid) begin found = 1; n = k; end
        end
        if (!found) chk({name, "_timeout"}, 0, 1);
        else begin
            if (lat) chk({name, "_latency"}, n, STAGES);
            chk(name, out_w, exp);
        end
        @(posedge clk);
    endtask

    task automatic cfg_write(input string name, input int s, input logic [2:0] m, input logic e);
        @(posedge clk); #1;
        cfg_we = 1; cfg_stage = SW'(s); cfg_inv = m;
        @(posedge clk); #1;
        cfg_we = 0;
        @(negedge clk);
        chk(name, cfg_err, e);
        @(negedge clk);
        chk({name, "_clear"}, cfg_err, 0);
    endtask

    initial begin
        // The side operands are {x,y}[4:0]; bit k-1 feeds stage k.
        tab[0] = '{1, 1, 0, 5'b11111, 5'b00000, 1};
        tab[1] = '{0, 0, 1, 5'b11111, 5'b00000, 0};
        tab[2] = '{1, 0, 1, 5'b00000, 5'b00000, 0};
        tab[3] = '{0, 0, 0, 5'b10000, 5'b10000, 1};
        tab[4] = '{1, 1, 1, 5'b01111, 5'b00000, 0};
        tab[5] = '{0, 1, 0, 5'b00001, 5'b11111, 1};
        tab[6] = '{0, 1, 1, 5'b00100, 5'b11011, 1};
        tab[7] = '{1, 0, 0, 5'b01010, 5'b10101, 0};
        tab[8] = '{0, 1, 0, 5'b11000, 5'b01111, 1};
        tab[9] = '{1, 1, 0, 5'b00110, 5'b01010, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_out_count", out_count, 0);

        // 20 back-to-back tokens, no gaps, in order
        got_w.delete(); got_cyc.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            apply(i % 10); in_valid = 1;
            @(posedge clk); #1;
        end
        in_valid = 0;
        for (int k = 0; k < 60 && got_w.size() < 20; k++) @(posedge clk);
        chk("stream_count", got_w.size(), 20);
        for (int i = 0; i < got_w.size() && i < 20; i++) begin
            chk($sformatf("stream_val%0d", i), got_w[i], tab[i % 10].exp);
            chk($sformatf("stream_gap%0d", i), got_cyc[i] - got_cyc[0], i);
        end
        repeat (2) @(negedge clk);
        chk("stream_out_count", out_count, 20);

        // Single token latency
        single("latency_tok", 0, 1, 1);

        // Five-cycle output stall mid-stream
        got_w.delete(); got_cyc.delete();
        fork
            begin
                int idx = 0;
                bit hs;
                @(posedge clk); #1;
                apply(0); in_valid = 1;
                for (int g = 0; g < 200 && idx < 10; g++) begin
                    @(negedge clk); hs = in_ready;
                    @(posedge clk); #1;
                    if (hs) begin
                        idx++;
                        if (idx < 10) apply(idx); else in_valid = 0;
                    end
                end
                in_valid = 0;
            end
            begin
                int kk;
                for (int k = 0; k < 100 && got_w.size() < 3; k++) @(posedge clk);
                #1 out_ready = 0;
                kk = got_w.size();
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk($sformatf("stall_in_ready%0d", s), in_ready, 0);
                    chk($sformatf("stall_out_w%0d", s), out_w, tab[kk].exp);
                    @(posedge clk); #1;
                end
                out_ready = 1;
            end
        join
        for (int k = 0; k < 60 && got_w.size() < 10; k++) @(posedge clk);
        chk("stall_count", got_w.size(), 10);
        for (int i = 0; i < got_w.size() && i < 10; i++)
            chk($sformatf("stall_val%0d", i), got_w[i], tab[i].exp);

        // Masks: invert carry at stage 3, then also at stage 5
        cfg_write("cfg_m3", 3, 3'b100, 0);
        single("mask_m3", 0, 0, 0);
        cfg_write("cfg_m5", 5, 3'b100, 0);
        single("mask_m3m5", 0, 1, 0);

        // Out-of-range stage is rejected
        cfg_write("cfg_range", 7, 3'b111, 1);
        single("after_range", 0, 1, 0);

        // Write while busy is rejected
        @(posedge clk); #1;
        apply(0); in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; cfg_we = 1; cfg_stage = 0; cfg_inv = 3'b111;
        @(negedge clk);
        chk("busy_flag", busy, 1);
        @(posedge clk); #1;
        cfg_we = 0;
        @(negedge clk);
        chk("busy_cfg_err", cfg_err, 1);
        @(negedge clk);
        chk("busy_cfg_err_clear", cfg_err, 0);
        wait_out("busy_tok", 1);
        @(posedge clk);
        single("after_busy", 0, 1, 0);

        // Write together with in_valid: token wins, write rejected
        @(posedge clk); #1;
        apply(0); in_valid = 1; cfg_we = 1; cfg_stage = 0; cfg_inv = 3'b111;
        @(posedge clk); #1;
        in_valid = 0; cfg_we = 0;
        @(negedge clk);
        chk("coll_cfg_err", cfg_err, 1);
        chk("coll_busy", busy, 1);
        wait_out("coll_tok", 1);
        @(posedge clk);
        single("after_coll", 0, 1, 0);

        // Back to M3 only, so the reset test can see masks clear
        cfg_write("cfg_m5_clr", 5, 3'b000, 0);
        single("m3_only", 0, 0, 0);

        // Reset with 4 tokens in flight
        got_w.delete(); got_cyc.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            apply(i); in_valid = 1;
            @(posedge clk); #1;
        end
        in_valid = 0; rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_count", out_count, 0);
        repeat (10) @(negedge clk);
        chk("mrst_no_output", got_w.size(), 0);
        single("mrst_masks", 0, 1, 0);
        repeat (2) @(negedge clk);
        chk("mrst_count_after", out_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/maj_chain_pipe.md
MAJ_CHAIN_PIPE -- requirements
Module: maj_chain_pipe

Interface
REQ-001 Parameter STAGES, default 6: number of majority stages in the chain; legal range 2..32.
REQ-002 Parameter W, default 1: lane width; every stage evaluates W independent bitwise majorities.
REQ-003 Localparam SW = max(1, clog2(STAGES)): width of the stage index.
REQ-004 clk  input  1  rising-edge clock; sole clock domain.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  input token present.
REQ-007 in_ready  output  1  block accepts the token this cycle.
REQ-008 in_a, in_b, in_c  input  W each  stage-0 majority operands.
REQ-009 in_x, in_y  input  (STAGES-1)*W each  side operands; slice [(k-1)*W +: W] feeds stage k (k=1..STAGES-1).
REQ-010 out_valid  output  1  result token present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_w  output  W  final-stage result.
REQ-013 cfg_we  input  1  inversion-mask write strobe.
REQ-014 cfg_stage  input  SW  stage index to write.
REQ-015 cfg_inv  input  3  inversion mask for that stage: bit0 first operand, bit1 second, bit2 third.
REQ-016 cfg_err  output  1  one-cycle pulse: a write was rejected.
REQ-017 busy  output  1  any pipeline stage holds a valid token.
REQ-018 out_count  output  16  number of completed output handshakes.

Function
REQ-019 Stage 0 SHALL compute r0 = MAJ(in_a^M0[0], in_b^M0[1], in_c^M0[2]), with each M0 bit replicated across W.
REQ-020 Stage k>=1 SHALL compute rk = MAJ(xk^Mk[0], yk^Mk[1], r(k-1)^Mk[2]), where MAJ(p,q,s) = pq|ps|qs, evaluated bitwise.
REQ-021 The block SHALL have exactly one register rank per stage, and each rank SHALL carry a valid bit.
REQ-022 The in_x and in_y slices for stage k SHALL be captured at acceptance and delayed alongside their token, so a token always meets its own side operands.
REQ-023 Advance condition: adv = ~out_valid | out_ready. On adv, every rank shifts one place, bubbles included.
REQ-024 When adv is 0, all ranks SHALL hold; bubbles do not collapse.
REQ-025 in_ready SHALL equal adv, combinationally.
REQ-026 An input handshake is in_valid & in_ready.
REQ-027 Latency: with no stall, a token accepted in cycle t appears on out_valid/out_w in cycle t+STAGES.
REQ-028 Throughput SHALL be one token per cycle while out_ready stays high.
REQ-029 out_w and out_valid SHALL be driven directly from the final rank register.
REQ-030 out_w SHALL hold stable while out_valid=1 and out_ready=0.
REQ-031 Mask semantics: masks are applied as each stage's register is loaded.
REQ-032 A cfg_we write SHALL be accepted only when busy=0, in_valid=0 and cfg_stage<STAGES.
REQ-033 An accepted write SHALL update Mk at the clock edge and apply from the next cycle on.
REQ-034 A rejected write SHALL leave every mask unchanged and pulse cfg_err high for exactly one cycle.
REQ-035 If cfg_we and in_valid are both asserted in the same cycle, the token SHALL be accepted and the write rejected.
REQ-036 busy SHALL be the OR of all rank valid bits.
REQ-037 out_count SHALL increment on out_valid & out_ready and wrap from 0xFFFF to 0.

Reset
REQ-038 While rst_n=0 at a clock edge, the block SHALL clear all valid bits and out_count, and set all masks to 3'b000 (plain majority chain).
REQ-039 After reset, out_valid=0, busy=0 and cfg_err=0; out_w and the data ranks are don't-care, and any tokens in flight are discarded.
REQ-040 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-041 Reset asserted mid-stream SHALL drop in-flight tokens, and no output handshake SHALL occur for them.

Verification
REQ-042 Scenario: STAGES=6, W=1, masks=0, a=1 b=1 c=0, all x=1 y=0, accept at t -> out_valid=1 and out_w=1 exactly at t+6.
REQ-043 Scenario: same stimulus with M3 set to 3'b100 (invert carry) -> out_w=0; adding M5=3'b100 -> out_w=1.
REQ-044 Scenario: 20 back-to-back tokens with random operands, out_ready=1 -> 20 results in order, matching the bitwise model, with no gaps; then out_count=20.
REQ-045 Scenario: out_ready held low for 5 cycles mid-stream -> in_ready=0 for those cycles, out_w stable, and no tokens lost or duplicated.
REQ-046 Scenario: cfg_we with busy=1, or with cfg_stage=7 on a 6-stage build -> cfg_err pulses for 1 cycle and masks are unchanged.
REQ-047 Scenario: rst_n low for 1 cycle with 4 tokens in flight -> busy=0 and out_valid=0 next cycle, masks=0, out_count=0.
